// File: rtl/bsg_manycore_io_dispatch_monitor.sv
// South-edge I/O dispatcher: steers loader packets to per-column registered link slots with
// outbound credit tracking, and folds per-column finish/fail events into one run-status FSM.
module bsg_manycore_io_dispatch_monitor #(
   parameter int unsigned num_channels_p    = 4,
   parameter int unsigned packet_width_p    = 80,
   parameter int unsigned chan_sel_lsb_p    = 0,
   parameter int unsigned max_out_credits_p = 4,
   parameter int unsigned finish_mode_p     = 0,
   parameter int unsigned timeout_cycles_p  = 0,
   parameter int unsigned cycle_width_p     = 40
) (
   input  logic                                                     clk_i,
   input  logic                                                     reset_n_i,
   input  logic                                                     start_i,
   input  logic [packet_width_p-1:0]                                load_data_i,
   input  logic                                                     load_v_i,
   output logic                                                     load_ready_o,
   output logic [num_channels_p*packet_width_p-1:0]                 link_data_o,
   output logic [num_channels_p-1:0]                                link_v_o,
   input  logic [num_channels_p-1:0]                                link_ready_i,
   input  logic [num_channels_p-1:0]                                credit_return_i,
   output logic [num_channels_p*$clog2(max_out_credits_p+1)-1:0]    out_credits_o,
   input  logic [num_channels_p-1:0]                                finish_i,
   input  logic [num_channels_p-1:0]                                fail_i,
   output logic [1:0]                                               state_o,
   output logic [cycle_width_p-1:0]                                 cycle_count_o,
   output logic                                                     finish_o,
   output logic                                                     success_o,
   output logic                                                     timeout_o,
   output logic                                                     err_o
);

   localparam int unsigned sel_w  = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
   localparam int unsigned cred_w = $clog2(max_out_credits_p + 1);
   localparam logic [cred_w-1:0]        cred_max_lp = cred_w'(max_out_credits_p);
   // Last RUN cycle value before a timeout; meaningless (and unused) when the timeout is off.
   localparam logic [cycle_width_p-1:0] tmo_last_lp = cycle_width_p'(timeout_cycles_p - 1);

   typedef enum logic [1:0] {
      st_idle    = 2'b00,
      st_run     = 2'b01,
      st_done    = 2'b10,
      st_timeout = 2'b11
   } state_e;

   state_e state_r, state_n;

   logic [num_channels_p-1:0][packet_width_p-1:0] slot_data_r;
   logic [num_channels_p-1:0]                     slot_v_r;
   logic [num_channels_p-1:0][cred_w-1:0]         cred_r;
   logic [num_channels_p-1:0]                     fin_r, fail_r;
   logic [cycle_width_p-1:0]                      cycle_r;
   logic                                          success_r, err_r;

   logic [sel_w-1:0]          chan_c;
   logic [num_channels_p-1:0] sel_c, push_c, overflow_c;
   logic                      chan_ok_c, ready_hit_c, active_c, acc_c, drop_c;
   logic                      done_c, tmo_c, run_c, cnt_en_c, latch_c;

   // Destination decode: one-hot select, all-zero when the column does not exist.
   always_comb begin
      chan_c = load_data_i[chan_sel_lsb_p +: sel_w];
      sel_c  = '0;
      for (int i = 0; i < int'(num_channels_p); i++)
         sel_c[i] = (chan_c == sel_w'(i));
      chan_ok_c = |sel_c;
   end

   // Accept when the target slot has a credit and is empty or emptying this cycle.
   always_comb begin
      ready_hit_c = 1'b0;
      for (int i = 0; i < int'(num_channels_p); i++)
         ready_hit_c = ready_hit_c |
                       (sel_c[i] & (cred_r[i] != '0) & (~slot_v_r[i] | link_ready_i[i]));
      active_c     = (state_r == st_idle) || (state_r == st_run);
      load_ready_o = active_c & (~chan_ok_c | ready_hit_c);
      acc_c        = load_v_i & load_ready_o;
      drop_c       = acc_c & ~chan_ok_c;
      push_c       = {num_channels_p{acc_c}} & sel_c;
      overflow_c   = '0;
      for (int i = 0; i < int'(num_channels_p); i++)
         overflow_c[i] = credit_return_i[i] & ~push_c[i] & (cred_r[i] == cred_max_lp);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         slot_v_r    <= '0;
         slot_data_r <= '0;
      end else begin
         for (int i = 0; i < int'(num_channels_p); i++) begin
            if (push_c[i]) begin
               slot_v_r[i]    <= 1'b1;
               slot_data_r[i] <= load_data_i;
            end else if (link_ready_i[i]) begin
               slot_v_r[i] <= 1'b0;
            end
         end
      end
   end

   // Credit counters saturate at the maximum; a simultaneous return and accept cancel.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < int'(num_channels_p); i++)
            cred_r[i] <= cred_max_lp;
      end else begin
         for (int i = 0; i < int'(num_channels_p); i++) begin
            case ({credit_return_i[i], push_c[i]})
               2'b10: if (cred_r[i] != cred_max_lp) cred_r[i] <= cred_r[i] + cred_w'(1);
               2'b01: cred_r[i] <= cred_r[i] - cred_w'(1);
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      done_c = (finish_mode_p != 0) ? (&(fin_r | finish_i)) : (|(fin_r | finish_i));
      tmo_c  = (timeout_cycles_p != 0) && (cycle_r == tmo_last_lp);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_r <= st_idle;
      else            state_r <= state_n;
   end

   // DONE takes priority over a timeout landing in the same cycle.
   always_comb begin
      state_n = state_r;
      case (state_r)
         st_idle: if (start_i) state_n = st_run;
         st_run: begin
            if (done_c)     state_n = st_done;
            else if (tmo_c) state_n = st_timeout;
         end
         default: ;
      endcase
   end

   always_comb begin
      run_c     = (state_r == st_run);
      cnt_en_c  = run_c & (state_n == st_run);
      latch_c   = run_c & done_c;
      state_o   = state_r;
      finish_o  = (state_r == st_done);
      timeout_o = (state_r == st_timeout);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cycle_r   <= '0;
         fin_r     <= '0;
         fail_r    <= '0;
         success_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         if (run_c) begin
            fin_r  <= fin_r | finish_i;
            fail_r <= fail_r | fail_i;
         end
         if (cnt_en_c) cycle_r <= cycle_r + cycle_width_p'(1);
         if (latch_c) success_r <= ~|(fail_r | fail_i);
         if (drop_c | (|overflow_c)) err_r <= 1'b1;
      end
   end

   assign link_data_o   = slot_data_r;
   assign link_v_o      = slot_v_r;
   assign out_credits_o = cred_r;
   assign cycle_count_o = cycle_r;
   assign success_o     = success_r;
   assign err_o         = err_r;

endmodule

// File: tb/tb_bsg_manycore_io_dispatch_monitor.sv
// Directed bench for bsg_manycore_io_dispatch_monitor: per-column scoreboard queues checked by a
// negedge link monitor, plus direct checks of credits, errors and run-status FSM.
module tb_bsg_manycore_io_dispatch_monitor;
   localparam int unsigned N  = 5;
   localparam int unsigned W  = 16;
   localparam int unsigned CW = 3;
   localparam int unsigned YW = 40;
   localparam logic [N*CW-1:0] CRED_FULL = {N{3'd4}};

   logic            clk = 1'b0;
   logic            reset_n;
   logic            start;
   logic [W-1:0]    load_data;
   logic            load_v;
   logic            load_ready;
   logic [N*W-1:0]  link_data;
   logic [N-1:0]    link_v;
   logic [N-1:0]    link_ready;
   logic [N-1:0]    credit_return;
   logic [N*CW-1:0] out_credits;
   logic [N-1:0]    finish;
   logic [N-1:0]    fail;
   logic [1:0]      state;
   logic [YW-1:0]   cycle_count;
   logic            finish_o, success_o, timeout_o, err_o;

   int n_checks = 0;
   int n_errs   = 0;
   logic [W-1:0] exp_q [N][$];

   always #5 clk = ~clk;

   bsg_manycore_io_dispatch_monitor #(
      .num_channels_p(N), .packet_width_p(W), .chan_sel_lsb_p(0), .max_out_credits_p(4),
      .finish_mode_p(1), .timeout_cycles_p(100), .cycle_width_p(YW)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
      .load_data_i(load_data), .load_v_i(load_v), .load_ready_o(load_ready),
      .link_data_o(link_data), .link_v_o(link_v), .link_ready_i(link_ready),
      .credit_return_i(credit_return), .out_credits_o(out_credits),
      .finish_i(finish), .fail_i(fail), .state_o(state), .cycle_count_o(cycle_count),
      .finish_o(finish_o), .success_o(success_o), .timeout_o(timeout_o), .err_o(err_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] cred(input int ch);
      return out_credits[ch*CW +: CW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one packet for one cycle; the bench decides whether it should be taken.
   task automatic issue(input logic [W-1:0] d, input logic exp_rdy);
      load_data = d;
      load_v    = 1'b1;
      #1;
      chk("load_ready", 64'(load_ready), 64'(exp_rdy));
      if (exp_rdy && (d[2:0] < 3'd5)) exp_q[int'(d[2:0])].push_back(d);
      tick();
      load_v = 1'b0;
   endtask

   task automatic return_credits(input int ch, input int n);
      credit_return[ch] = 1'b1;
      repeat (n) tick();
      credit_return[ch] = 1'b0;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      link_ready = '0; credit_return = '0; finish = '0; fail = '0; start = 1'b0; load_v = 1'b0;
      for (int ch = 0; ch < N; ch++) exp_q[ch].delete();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Link monitor: a handshake completes at the next posedge, so pop and compare here.
   always @(negedge clk) begin
      if (reset_n) begin
         for (int ch = 0; ch < N; ch++) begin
            if (link_v[ch] && link_ready[ch]) begin
               if (exp_q[ch].size() == 0) begin
                  n_checks++;
                  n_errs++;
                  $display("FAIL link%0d_unexpected: got %0h expected none", ch,
                           link_data[ch*W +: W]);
               end else begin
                  chk($sformatf("link%0d_data", ch), 64'(link_data[ch*W +: W]),
                      64'(exp_q[ch].pop_front()));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of stimulus expected finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; load_data = '0; load_v = 1'b0;
      link_ready = '0; credit_return = '0; finish = '0; fail = '0;
      tick();
      chk("rst_state", 64'(state), 64'(0));
      chk("rst_link_v", 64'(link_v), 64'(0));
      chk("rst_credits", 64'(out_credits), 64'(CRED_FULL));
      chk("rst_cycle", 64'(cycle_count), 64'(0));
      chk("rst_flags", 64'({finish_o, success_o, timeout_o, err_o}), 64'(0));
      chk("rst_ready", 64'(load_ready), 64'(1));
      reset_n = 1'b1;
      tick();

      // Credit exhaustion on column 2, then one return re-opens it.
      link_ready[2] = 1'b1;
      issue(16'h0A02, 1'b1);
      issue(16'h0B02, 1'b1);
      issue(16'h0C02, 1'b1);
      issue(16'h0D02, 1'b1);
      chk("c2_cred_empty", 64'(cred(2)), 64'(0));
      load_data = 16'h0E02; load_v = 1'b1;
      #1;
      chk("c2_stall", 64'(load_ready), 64'(0));
      credit_return[2] = 1'b1;
      tick();
      credit_return[2] = 1'b0;
      load_v = 1'b0;
      chk("c2_cred_one", 64'(cred(2)), 64'(1));
      issue(16'h0E02, 1'b1);
      chk("c2_cred_zero", 64'(cred(2)), 64'(0));
      return_credits(2, 4);
      chk("c2_cred_full", 64'(cred(2)), 64'(4));
      link_ready = '0;

      // Full-throughput streaming on column 1.
      link_ready[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(16'(16'hB001 + (i << 8)), 1'b1);
         chk("c1_stream_v", 64'(link_v), 64'(5'b00010));
      end
      tick();
      chk("c1_drained", 64'(link_v), 64'(0));
      return_credits(1, 4);
      link_ready = '0;

      // Simultaneous return/accept, then overflow on a full counter.
      link_ready[3] = 1'b1;
      issue(16'h0003, 1'b1);
      issue(16'h0013, 1'b1);
      chk("c3_cred_two", 64'(cred(3)), 64'(2));
      credit_return[3] = 1'b1;
      issue(16'h0023, 1'b1);
      credit_return[3] = 1'b0;
      chk("c3_ret_acc", 64'(cred(3)), 64'(2));
      return_credits(3, 2);
      chk("c3_cred_full", 64'(cred(3)), 64'(4));
      chk("err_clear", 64'(err_o), 64'(0));
      return_credits(3, 1);
      chk("c3_saturate", 64'(cred(3)), 64'(4));
      chk("err_overflow", 64'(err_o), 64'(1));
      tick();
      do_reset();

      // Nonexistent columns are swallowed and flagged.
      issue(16'h1235, 1'b1);
      chk("bad_err", 64'(err_o), 64'(1));
      chk("bad_no_v", 64'(link_v), 64'(0));
      issue(16'h00F7, 1'b1);
      chk("bad_credits", 64'(out_credits), 64'(CRED_FULL));

      // Asynchronous reset in the middle of a run with a held packet.
      start_run();
      chk("run_state", 64'(state), 64'(1));
      issue(16'hAB00, 1'b1);
      chk("held_v", 64'(link_v), 64'(5'b00001));
      chk("held_cred", 64'(cred(0)), 64'(3));
      repeat (3) tick();
      chk("mid_cycle", 64'(cycle_count), 64'(4));
      #2;
      reset_n = 1'b0;
      #1;
      for (int ch = 0; ch < N; ch++) exp_q[ch].delete();
      chk("arst_state", 64'(state), 64'(0));
      chk("arst_link_v", 64'(link_v), 64'(0));
      chk("arst_data", 64'(link_data[W-1:0]), 64'(0));
      chk("arst_credits", 64'(out_credits), 64'(CRED_FULL));
      chk("arst_cycle", 64'(cycle_count), 64'(0));
      chk("arst_flags", 64'({finish_o, success_o, timeout_o, err_o}), 64'(0));
      tick();
      reset_n = 1'b1;
      tick();

      // All-columns finish mode.
      finish = '1;
      tick();
      finish = '0;
      chk("idle_fin_ignored", 64'(state), 64'(0));
      start_run();
      for (int i = 0; i < 4; i++) begin
         finish = 5'(1 << i);
         tick();
      end
      finish = '0;
      chk("partial_fin", 64'(state), 64'(1));
      finish = 5'b10000;
      tick();
      finish = '0;
      chk("all_fin_state", 64'(state), 64'(2));
      chk("all_fin_flags", 64'({finish_o, success_o, timeout_o}), 64'(3'b110));
      chk("done_cycle", 64'(cycle_count), 64'(4));
      start_run();
      repeat (2) tick();
      chk("done_frozen", 64'(cycle_count), 64'(4));
      chk("done_start_ign", 64'(state), 64'(2));

      do_reset();
      start_run();
      fail = 5'b00100;
      tick();
      fail = '0;
      finish = '1;
      tick();
      finish = '0;
      chk("fail_state", 64'(state), 64'(2));
      chk("fail_success", 64'(success_o), 64'(0));

      do_reset();
      start_run();
      finish = '1; fail = 5'b00001;
      tick();
      finish = '0; fail = '0;
      chk("samecyc_fail", 64'({finish_o, success_o}), 64'(2'b10));

      // Timeout after 100 RUN cycles, and DONE winning on the last one.
      do_reset();
      start_run();
      repeat (99) tick();
      chk("pre_tmo_state", 64'(state), 64'(1));
      chk("pre_tmo_cycle", 64'(cycle_count), 64'(99));
      tick();
      chk("tmo_state", 64'(state), 64'(3));
      chk("tmo_flags", 64'({finish_o, timeout_o}), 64'(2'b01));
      chk("tmo_cycle", 64'(cycle_count), 64'(99));
      repeat (2) tick();
      chk("tmo_frozen", 64'(cycle_count), 64'(99));

      do_reset();
      start_run();
      repeat (99) tick();
      finish = '1;
      tick();
      finish = '0;
      chk("race_state", 64'(state), 64'(2));
      chk("race_flags", 64'({finish_o, success_o, timeout_o}), 64'(3'b110));
      chk("race_cycle", 64'(cycle_count), 64'(99));

      repeat (2) tick();
      for (int ch = 0; ch < N; ch++)
         chk($sformatf("sb%0d_empty", ch), 64'(exp_q[ch].size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
